// File: rtl/nco_pkg.sv
// Shared types and elaboration-time helpers for axis_nco_source.
// The optional quarter-wave LUT is selected with NCO_QUARTER_WAVE_LUT_EN.
package nco_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   // Quadrant of a LUT address (top two address bits)
   typedef enum logic [1:0] {
      Q0 = 2'd0,
      Q1 = 2'd1,
      Q2 = 2'd2,
      Q3 = 2'd3
   } quad_e;

   localparam real NCO_PI = 3.141592653589793;

   // round(A*sin(2*pi*k/2^lw)) with A = 2^(ow-1)-1; evaluated at elaboration only
   function automatic int lut_entry(input int k, input int lw, input int ow);
      real amp;
      real x;
      amp = real'((1 << (ow - 1)) - 1);
      x   = amp * $sin(2.0 * NCO_PI * real'(k) / real'(1 << lw));
      return int'(x);
   endfunction

endpackage

// File: rtl/axis_nco_source_if.sv
// AXI-Stream sample channel between the NCO source and the filter chain.
interface axis_nco_source_if #(
   parameter int unsigned OW = 8
);
   logic signed [OW-1:0] tdata;
   logic                 tvalid;
   logic                 tlast;
   logic                 tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/nco_sine_lut.sv
// Stage-2 data path: registered LUT address -> registered sine sample.
// NCO_QUARTER_WAVE_LUT_EN selects a first-quadrant table with symmetry decode;
// otherwise a full-wave table is indexed directly. Outputs are identical.
module nco_sine_lut
   import nco_pkg::*;
#(
   parameter int unsigned OW = 8,
   parameter int unsigned LW = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [LW-1:0]        addr,
   output logic signed [OW-1:0] data_q
);

   logic signed [OW-1:0] data_d;

`ifdef NCO_QUARTER_WAVE_LUT_EN
   localparam int unsigned QN = 2 ** (LW - 2);
   localparam logic [LW-2:0] QN_IDX = (LW-1)'(QN);

   logic signed [OW-1:0] tbl [QN+1];
   quad_e                quad;
   logic [LW-3:0]        ofs;
   logic [LW-2:0]        idx;
   logic signed [OW-1:0] mag;

   for (genvar g = 0; g <= int'(QN); g++) begin : g_tbl
      assign tbl[g] = OW'(lut_entry(g, int'(LW), int'(OW)));
   end

   // Fold the address into the first quadrant and restore sign
   always_comb begin
      quad   = quad_e'(addr[LW-1 -: 2]);
      ofs    = addr[LW-3:0];
      idx    = {1'b0, ofs};
      mag    = '0;
      data_d = '0;
      if (quad == Q1 || quad == Q3) begin
         idx = QN_IDX - {1'b0, ofs};
      end
      mag = tbl[idx];
      if (quad == Q2 || quad == Q3) begin
         data_d = -mag;
      end else begin
         data_d = mag;
      end
   end
`else
   logic signed [OW-1:0] tbl [2**LW];

   for (genvar g = 0; g < int'(2 ** LW); g++) begin : g_tbl
      assign tbl[g] = OW'(lut_entry(g, int'(LW), int'(OW)));
   end

   // Direct full-wave lookup
   always_comb begin
      data_d = tbl[addr];
   end
`endif

   // Output sample register, held while the stream is stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else if (en) begin
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/axis_nco_source.sv
// AXI-Stream NCO tone source: phase accumulator + sine LUT, two-stage pipeline,
// burst (tlast-terminated) or continuous mode, full backpressure support.
// Optional build macro: NCO_QUARTER_WAVE_LUT_EN (quarter-wave LUT in nco_sine_lut).
module axis_nco_source
   import nco_pkg::*;
#(
   parameter int unsigned OW = 8,
   parameter int unsigned PW = 32,
   parameter int unsigned LW = 8,
   parameter int unsigned BW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          stop,
   input  logic [PW-1:0] phase_inc,
   input  logic [BW-1:0] burst_len,
   output logic          busy,
   axis_nco_source_if.master axis_o
);

   state_e        state_q, state_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [PW-1:0] inc_q, inc_d;
   logic [BW-1:0] len_q, len_d;
   logic [BW-1:0] count_q, count_d;
   logic [LW-1:0] addr_q, addr_d;
   logic          v1_q, v1_d;
   logic          last1_q, last1_d;
   logic          tvalid_q, tvalid_d;
   logic          tlast_q, tlast_d;
   logic          busy_q, busy_d;
   logic          en;
   logic          issue;
   logic          last_hit;
   logic signed [OW-1:0] sample;

   assign en = !tvalid_q || axis_o.tready;

   // Control FSM, stage-1 issue and stage-2 valid/last
   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      inc_d    = inc_q;
      len_d    = len_q;
      count_d  = count_q;
      addr_d   = addr_q;
      v1_d     = v1_q;
      last1_d  = last1_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      issue    = 1'b0;
      last_hit = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               inc_d   = phase_inc;
               len_d   = burst_len;
               phase_d = '0;
               count_d = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = DRAIN;
            end else if (en) begin
               issue   = 1'b1;
               addr_d  = phase_q[PW-1 -: LW];
               phase_d = phase_q + inc_q;
               count_d = count_q + BW'(1);
               if (len_q != '0 && count_q == len_q - BW'(1)) begin
                  last_hit = 1'b1;
                  state_d  = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (!v1_q && en) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (en) begin
         v1_d     = issue;
         last1_d  = last_hit;
         tvalid_d = v1_q;
         tlast_d  = last1_q;
      end

      busy_d = (state_d != IDLE);
   end

   // State and pipeline registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         phase_q  <= '0;
         inc_q    <= '0;
         len_q    <= '0;
         count_q  <= '0;
         addr_q   <= '0;
         v1_q     <= 1'b0;
         last1_q  <= 1'b0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         inc_q    <= inc_d;
         len_q    <= len_d;
         count_q  <= count_d;
         addr_q   <= addr_d;
         v1_q     <= v1_d;
         last1_q  <= last1_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         busy_q   <= busy_d;
      end
   end

   nco_sine_lut #(
      .OW (OW),
      .LW (LW)
   ) u_lut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .addr   (addr_q),
      .data_q (sample)
   );

   assign busy          = busy_q;
   assign axis_o.tvalid = tvalid_q;
   assign axis_o.tlast  = tlast_q;
   assign axis_o.tdata  = sample;

endmodule
